// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Holds the buffer-state encoding and the pop-headroom helper.
package fifo_pkg;

  localparam int WORD_SIZE_DEF = 8;
  localparam int WORDS_OUT_W   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // A pop is safe when buffered words plus the word already in flight,
  // minus the word leaving this cycle, still leaves a free slot.
  function automatic logic pop_allowed(input logic [1:0] occ,
                                       input logic       infl,
                                       input logic       xfer);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, infl} - {2'b00, xfer};
    return (pending < 3'd2);
  endfunction

endpackage

// File: rtl/fifo_reader_chk.sv
// Checker for fifo_reader: watches the ports and flags a buffer overflow,
// i.e. a returning pop landing in a full buffer with nothing leaving.
module fifo_reader_chk (
  input logic       clk,
  input logic       rst,
  input logic       fifo_re,
  input logic       flush,
  input logic       m_valid,
  input logic       m_ready,
  input logic [1:0] occupancy
);

  logic infl_r;

  // Track the pop whose data returns in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_r <= 1'b0;
    end else begin
      infl_r <= fifo_re;
    end
  end

  // Overflow and illegal-occupancy checks.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(infl_r && !flush && occupancy == 2'd2 && !(m_valid && m_ready)));
      assert (occupancy != 2'd3);
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Adapts a 1-cycle-latency FIFO read port to a valid/ready stream through
// a 2-entry in-order skid buffer, with flush and a transfer counter.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_re,
  input  logic [WORD_SIZE-1:0]   fifo_rdata,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WORD_SIZE-1:0]   m_data,
  output logic [1:0]             occupancy,
  output logic [WORDS_OUT_W-1:0] words_out
);

  buf_state_e             state_r, state_s;
  logic [WORD_SIZE-1:0]   head_r, head_s;
  logic [WORD_SIZE-1:0]   tail_r, tail_s;
  logic                   inflight_r;
  logic                   run_r;
  logic                   transfer_s;
  logic                   write_s;
  logic [WORDS_OUT_W-1:0] words_out_r;

  assign m_valid    = (state_r != EMPTY);
  assign m_data     = head_r;
  assign occupancy  = state_r;
  assign words_out  = words_out_r;
  assign transfer_s = m_valid & m_ready;
  assign write_s    = inflight_r;

  // run_r holds pops off until the first edge after reset releases.
  assign fifo_re = run_r & ~fifo_empty & ~flush
                 & pop_allowed(state_r, inflight_r, transfer_s);

  // Next buffer state and contents; head always carries the oldest word.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    tail_s  = tail_r;
    if (flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (write_s) begin
            state_s = ONE;
            head_s  = fifo_rdata;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (write_s && transfer_s) begin
            state_s = ONE;
            head_s  = fifo_rdata;
          end else if (write_s) begin
            state_s = TWO;
            tail_s  = fifo_rdata;
          end else if (transfer_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        TWO: begin
          if (transfer_s) begin
            state_s = ONE;
            head_s  = tail_r;
          end else begin
            state_s = TWO;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
  end

  // State, data, in-flight flag and transfer counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      head_r      <= '0;
      tail_r      <= '0;
      inflight_r  <= 1'b0;
      run_r       <= 1'b0;
      words_out_r <= '0;
    end else begin
      state_r    <= state_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      inflight_r <= fifo_re & ~flush;
      run_r      <= 1'b1;
      if (transfer_s) begin
        words_out_r <= words_out_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed table, hand sequences and a
// randomized run against a queue-based model of the buffer and counter.
module tb_fifo_reader;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_re;
  logic [W-1:0] fifo_rdata;
  logic         flush;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;
  logic [15:0]  words_out;

  always #5 clk = ~clk;

  fifo_reader #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_rdata(fifo_rdata), .flush(flush), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .occupancy(occupancy),
    .words_out(words_out)
  );

  fifo_reader_chk u_chk (
    .clk(clk), .rst(rst), .fifo_re(fifo_re), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .occupancy(occupancy)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Source FIFO contents and reference model of the adapter.
  logic [W-1:0] src_q[$];
  logic [W-1:0] buf_m[$];
  bit           infl_m;
  logic [15:0]  cnt_m;

  typedef struct {
    bit          push;
    logic [7:0]  d;
    bit          rdy;
    bit          fl;
    logic        e_valid;
    logic [7:0]  e_data;
    logic [1:0]  e_occ;
    logic        e_re;
    logic [15:0] e_wo;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(bit p, logic [7:0] d, bit r, bit f, logic v,
                              logic [7:0] ed, logic [1:0] eo, logic ere,
                              logic [15:0] ew);
    vec_t t;
    t.push = p; t.d = d; t.rdy = r; t.fl = f; t.e_valid = v;
    t.e_data = ed; t.e_occ = eo; t.e_re = ere; t.e_wo = ew;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    buf_m.delete();
    infl_m = 1'b0;
    cnt_m  = 16'd0;
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle(input bit push_en, input logic [7:0] push_d,
                       input bit rdy, input bit fl,
                       output logic [7:0] a_data, output logic a_valid,
                       output logic [1:0] a_occ, output logic a_re,
                       output logic [15:0] a_wo);
    bit e_valid, e_re, xfer;
    if (push_en) src_q.push_back(push_d);
    m_ready    = rdy;
    flush      = fl;
    fifo_empty = (src_q.size() == 0);
    e_valid    = (buf_m.size() > 0);
    xfer       = e_valid && rdy;
    e_re       = !fifo_empty && !fl &&
                 ((int'(buf_m.size()) + int'(infl_m) - int'(xfer)) < 2);
    @(negedge clk);
    a_data = m_data; a_valid = m_valid; a_occ = occupancy;
    a_re = fifo_re; a_wo = words_out;
    chk("m_valid", m_valid, e_valid);
    if (e_valid) chk("m_data", m_data, buf_m[0]);
    chk("occupancy", occupancy, buf_m.size());
    chk("fifo_re", fifo_re, e_re);
    chk("words_out", words_out, cnt_m);
    @(posedge clk);
    #1;
    if (xfer) begin
      void'(buf_m.pop_front());
      cnt_m = cnt_m + 16'd1;
    end
    if (fl) begin
      buf_m.delete();
    end else if (infl_m) begin
      buf_m.push_back(fifo_rdata);
    end
    infl_m = e_re;
    if (e_re) fifo_rdata = src_q.pop_front();
    else      fifo_rdata = 8'($urandom);
  endtask

  initial begin
    logic [7:0]  a_data;
    logic        a_valid, a_re;
    logic [1:0]  a_occ;
    logic [15:0] a_wo;
    logic [15:0] start;
    int          got, gaps;
    bit          seen;

    rst = 1'b1; m_ready = 1'b1; flush = 1'b0; fifo_empty = 1'b0;
    fifo_rdata = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_words_out", words_out, 16'd0);
    chk("rst_fifo_re", fifo_re, 1'b0);
    fifo_empty = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: single word latency, fill to two, head promotion, flush.
    tbl[0]  = mk(1, 8'hA5, 1, 0, 0, 8'h00, 2'd0, 1, 16'd0);
    tbl[1]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 2'd0, 0, 16'd0);
    tbl[2]  = mk(0, 8'h00, 1, 0, 1, 8'hA5, 2'd1, 0, 16'd0);
    tbl[3]  = mk(1, 8'h11, 0, 0, 0, 8'h00, 2'd0, 1, 16'd1);
    tbl[4]  = mk(1, 8'h22, 0, 0, 0, 8'h00, 2'd0, 1, 16'd1);
    tbl[5]  = mk(1, 8'h33, 0, 0, 1, 8'h11, 2'd1, 0, 16'd1);
    tbl[6]  = mk(0, 8'h00, 0, 0, 1, 8'h11, 2'd2, 0, 16'd1);
    tbl[7]  = mk(0, 8'h00, 1, 0, 1, 8'h11, 2'd2, 1, 16'd1);
    tbl[8]  = mk(0, 8'h00, 1, 0, 1, 8'h22, 2'd1, 0, 16'd2);
    tbl[9]  = mk(0, 8'h00, 0, 1, 1, 8'h33, 2'd1, 0, 16'd3);
    tbl[10] = mk(0, 8'h00, 1, 0, 0, 8'h00, 2'd0, 0, 16'd3);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].push, tbl[i].d, tbl[i].rdy, tbl[i].fl, a_data, a_valid, a_occ, a_re, a_wo);
      chk($sformatf("tbl%0d_valid", i), a_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), a_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_occ", i), a_occ, tbl[i].e_occ);
      chk($sformatf("tbl%0d_re", i), a_re, tbl[i].e_re);
      chk($sformatf("tbl%0d_wo", i), a_wo, tbl[i].e_wo);
    end

    // Back-to-back: 16 preloaded words with m_ready held high.
    for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
    start = cnt_m; got = 0; gaps = 0; seen = 0;
    for (int c = 0; c < 24; c++) begin
      cycle(0, 8'h00, 1, 0, a_data, a_valid, a_occ, a_re, a_wo);
      if (a_valid) begin
        seen = 1;
        if (got < 16) chk($sformatf("b2b_word%0d", got), a_data, got + 1);
        got++;
      end else if (seen && got < 16) begin
        gaps++;
      end
    end
    chk("b2b_count", got, 16);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_words_out", words_out, start + 16'd16);

    // Backpressure: 4 words, m_ready low for 10 cycles, then drain.
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hC0 + i));
    for (int c = 0; c < 10; c++) begin
      cycle(0, 8'h00, 0, 0, a_data, a_valid, a_occ, a_re, a_wo);
      if (a_valid) chk("bp_stable", a_data, 8'hC0);
    end
    chk("bp_occ", a_occ, 2'd2);
    chk("bp_re", a_re, 1'b0);
    got = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(0, 8'h00, 1, 0, a_data, a_valid, a_occ, a_re, a_wo);
      if (a_valid && got < 4) begin
        chk($sformatf("bp_word%0d", got), a_data, 8'hC0 + got);
        got++;
      end
    end
    chk("bp_count", got, 4);

    // Flush with a transfer in the flush cycle and a pop in flight.
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hD0 + i));
    for (int c = 0; c < 4; c++) cycle(0, 8'h00, 0, 0, a_data, a_valid, a_occ, a_re, a_wo);
    chk("fl_full", a_occ, 2'd2);
    start = cnt_m;
    cycle(0, 8'h00, 1, 0, a_data, a_valid, a_occ, a_re, a_wo);
    chk("fl_pop_issued", a_re, 1'b1);
    cycle(0, 8'h00, 1, 1, a_data, a_valid, a_occ, a_re, a_wo);
    cycle(0, 8'h00, 0, 0, a_data, a_valid, a_occ, a_re, a_wo);
    chk("fl_valid", a_valid, 1'b0);
    chk("fl_occ", a_occ, 2'd0);
    chk("fl_wo", a_wo, start + 16'd2);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(0, 8'h00, 1, 0, a_data, a_valid, a_occ, a_re, a_wo);
      if (a_valid && !seen) begin
        chk("fl_next_word", a_data, 8'hD3);
        seen = 1;
      end
    end
    chk("fl_found", seen, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      cycle((src_q.size() < 8) && ($urandom_range(0, 1) == 1), 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
            a_data, a_valid, a_occ, a_re, a_wo);
    end

    // Counter wrap: stream until the count reaches FFFF, then one more.
    for (int c = 0; c < 70000 && cnt_m != 16'hFFFF; c++)
      cycle(1, 8'($urandom), 1, 0, a_data, a_valid, a_occ, a_re, a_wo);
    chk("wrap_ffff", words_out, 16'hFFFF);
    for (int c = 0; c < 10 && cnt_m != 16'h0000; c++)
      cycle(1, 8'($urandom), 1, 0, a_data, a_valid, a_occ, a_re, a_wo);
    chk("wrap_zero", words_out, 16'h0000);

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 5; c++) cycle(1, 8'($urandom), 1, 0, a_data, a_valid, a_occ, a_re, a_wo);
    fifo_empty = (src_q.size() == 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_m_data", m_data, 8'h00);
    chk("arst_occupancy", occupancy, 2'd0);
    chk("arst_words_out", words_out, 16'd0);
    chk("arst_fifo_re", fifo_re, 1'b0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rel_fifo_re", fifo_re, 1'b0);
    @(posedge clk);
    #1;
    fifo_rdata = 8'($urandom);
    for (int c = 0; c < 40; c++)
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, 0,
            a_data, a_valid, a_occ, a_re, a_wo);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter: WORD_SIZE, default 8, width of the FIFO and stream data words.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: fifo_empty  input  1  FIFO empty flag; high means no word available.
REQ-005 Port: fifo_re  output  1  FIFO pop request.
REQ-006 Port: fifo_rdata  input  WORD_SIZE  FIFO read data; valid in the cycle after an accepted pop.
REQ-007 Port: flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-008 Port: m_valid  output  1  stream word available.
REQ-009 Port: m_ready  input  1  downstream accepts the word.
REQ-010 Port: m_data  output  WORD_SIZE  stream data word.
REQ-011 Port: occupancy  output  2  number of words held in the output buffer (0..2).
REQ-012 Port: words_out  output  16  running count of stream transfers.

Function
REQ-013 The block SHALL convert the FIFO read port (pop with 1-cycle read latency) into a valid/ready stream with no bubbles at steady state.
REQ-014 The output buffer SHALL be 2 entries deep, in-order; m_data SHALL always present the oldest entry.
REQ-015 Buffer state SHALL be one of EMPTY (0), ONE (1), TWO (2), reflected on occupancy; m_valid = (state != EMPTY).
REQ-016 A stream transfer SHALL occur on any cycle with m_valid && m_ready.
REQ-017 An in-flight flag SHALL be set in the cycle after fifo_re was high and cleared otherwise; the word on fifo_rdata SHALL be written into the buffer while the flag is high.
REQ-018 fifo_re SHALL equal ~fifo_empty && ~flush && (occupancy + inflight - transfer) < 2. This is a combinational path from m_ready.
REQ-019 The fifo_re expression SHALL prevent buffer overflow. A write into a full buffer without a simultaneous transfer is a design error, and the verification engineer SHALL check it with an assertion.
REQ-020 Transitions:
  - EMPTY: write -> ONE.
  - ONE: write without transfer -> TWO; transfer without write -> EMPTY; write with transfer -> ONE, and the new word becomes head.
  - TWO: transfer -> ONE, and the second entry becomes head.
REQ-021 Latency: when fifo_empty falls with the buffer idle, fifo_re SHALL rise in the same cycle and m_valid SHALL rise 2 cycles later.
REQ-022 m_data SHALL hold stable while m_valid && ~m_ready.
REQ-023 words_out SHALL increment by 1 per transfer and wrap from 16'hFFFF to 0.
REQ-024 flush SHALL take effect at the next edge:
  - state -> EMPTY and the in-flight flag cleared;
  - a word arriving on fifo_rdata in the flush cycle or the cycle after SHALL be discarded;
  - words_out SHALL be unaffected;
  - a transfer in the flush cycle SHALL still be counted.
REQ-025 If fifo_empty is high, fifo_re SHALL be low regardless of buffer space.

Reset
REQ-026 While rst is high:
  - m_valid = 0, m_data = 0, occupancy = 0, words_out = 0;
  - the in-flight flag is cleared;
  - fifo_re = 0.
REQ-027 Reset assertion mid-transfer SHALL discard buffered and in-flight words. The first fifo_re after reset SHALL occur no earlier than the first clock edge after rst falls.

Structure
REQ-028 Shared package fifo_pkg SHALL hold:
  - the WORD_SIZE default;
  - the enumerated buffer-state type (EMPTY, ONE, TWO);
  - the words_out width constant (16).
REQ-029 The block SHALL be a single module with no sub-modules; the 2-entry buffer, in-flight flag and counter are inline.
REQ-030 The block SHALL connect directly to the team FIFO read side: empty -> fifo_empty, re <- fifo_re, rdata -> fifo_rdata.

Verification
REQ-031 Single word: FIFO preloaded with 8'hA5, m_ready = 1 -> fifo_re high in cycle 0, m_valid with m_data = 8'hA5 in cycle 2, words_out = 1.
REQ-032 Back-to-back: FIFO holding 8'h01..8'h10, m_ready held at 1 -> 16 consecutive transfers in order with no m_valid gaps after the first, words_out = 16.
REQ-033 Backpressure: 4 words loaded, m_ready = 0 for 10 cycles -> occupancy = 2, fifo_re low, m_data stable at the first word; after m_ready = 1, all 4 words arrive in order.
REQ-034 Flush: flush pulsed while occupancy = 2 with a pop in flight -> occupancy = 0 and m_valid = 0 next cycle, the in-flight word is never presented, and the next word popped appears correctly.
REQ-035 Wrap and reset:
  - preset words_out to 16'hFFFF via transfers, then one more transfer -> words_out = 0;
  - rst asserted mid-stream -> all outputs 0 asynchronously.
